// File: rtl/bsg_adder_serial_chunked_if.sv
// Operand/result handshake bundle for the chunked serial adder.
// The master drives operands and yumi; the slave (the adder) drives ready, valid and the result.
interface bsg_adder_serial_chunked_if #(parameter int width_p = 128);
   logic               v_i;
   logic               ready_o;
   logic [width_p-1:0] a_i;
   logic [width_p-1:0] b_i;
   logic               c_i;
   logic               v_o;
   logic               yumi_i;
   logic [width_p-1:0] s_o;
   logic               c_o;

   modport master (
      output v_i, a_i, b_i, c_i, yumi_i,
      input  ready_o, v_o, s_o, c_o
   );

   modport slave (
      input  v_i, a_i, b_i, c_i, yumi_i,
      output ready_o, v_o, s_o, c_o
   );
endinterface

// File: rtl/bsg_adder_serial_chunked.sv
// Multi-cycle adder: latches one operand pair, then adds chunk_p bits per cycle LSB first,
// rippling the carry through a register, and holds the result until the consumer takes it.
module bsg_adder_serial_chunked #(
   parameter int width_p = 128,
   parameter int chunk_p = 32
) (
   input logic                      clk_i,
   input logic                      reset_n_i,
   bsg_adder_serial_chunked_if.slave bus
);

   localparam int chunks_lp    = width_p / chunk_p;
   localparam int cnt_width_lp = (chunks_lp > 1) ? $clog2(chunks_lp) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e                                state_q, state_d;
   logic [cnt_width_lp-1:0]               cnt_q, cnt_d;
   logic                                  carry_q, carry_d;
   logic [chunks_lp-1:0][chunk_p-1:0]     a_q, a_d;
   logic [chunks_lp-1:0][chunk_p-1:0]     b_q, b_d;
   logic [chunks_lp-1:0][chunk_p-1:0]     s_q, s_d;
   logic                                  c_q, c_d;
   logic [chunk_p:0]                      chunkSum;
   logic                                  lastChunk;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         c_q     <= c_d;
      end
   end

   // The chunk selected by the counter is summed with the carry left by the previous chunk.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      s_d       = s_q;
      c_d       = c_q;
      chunkSum  = {1'b0, a_q[cnt_q]} + {1'b0, b_q[cnt_q]} + {{chunk_p{1'b0}}, carry_q};
      lastChunk = (cnt_q == cnt_width_lp'(chunks_lp - 1));

      case (state_q)
         IDLE: begin
            if (bus.v_i) begin
               a_d     = bus.a_i;
               b_d     = bus.b_i;
               carry_d = bus.c_i;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            s_d[cnt_q] = chunkSum[chunk_p-1:0];
            carry_d    = chunkSum[chunk_p];
            cnt_d      = cnt_q + 1'b1;
            if (lastChunk) begin
               c_d     = chunkSum[chunk_p];
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.yumi_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ready_o = (state_q == IDLE);
   assign bus.v_o     = (state_q == DONE);
   assign bus.s_o     = s_q;
   assign bus.c_o     = c_q;

endmodule

// File: tb/tb_bsg_adder_serial_chunked.sv
// Scoreboard bench: drivers push a+b+c_i into a queue at acceptance, monitors compare whenever v_o is up.
// Covers the default 128/32 configuration and a single-chunk 32/32 instance.
module tb_bsg_adder_serial_chunked;

   localparam int W  = 128;
   localparam int C  = 32;
   localparam int N  = W / C;
   localparam int W2 = 32;

   logic clk = 1'b0;
   logic rstN;
   int   checks = 0;
   int   errors = 0;

   logic [W:0]  expQ[$];
   logic [W2:0] expQ2[$];

   always #5 clk = ~clk;

   bsg_adder_serial_chunked_if #(.width_p(W))  bus  ();
   bsg_adder_serial_chunked_if #(.width_p(W2)) bus2 ();

   bsg_adder_serial_chunked #(.width_p(W), .chunk_p(C)) dut (
      .clk_i     (clk),
      .reset_n_i (rstN),
      .bus       (bus)
   );

   bsg_adder_serial_chunked #(.width_p(W2), .chunk_p(W2)) dut2 (
      .clk_i     (clk),
      .reset_n_i (rstN),
      .bus       (bus2)
   );

   task automatic checkOutput(input string name, input logic [W:0] act, input logic [W:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] randWide();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) begin
         r[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      end
      return r;
   endfunction

   // Every cycle the result is valid it must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rstN === 1'b1 && bus.v_o) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_v_o", (W+1)'(bus.v_o), '0);
         end else begin
            checkOutput("result", {bus.c_o, bus.s_o}, expQ[0]);
            if (bus.yumi_i) void'(expQ.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rstN === 1'b1 && bus2.v_o) begin
         if (expQ2.size() == 0) begin
            checkOutput("unexpected_v_o_w32", (W+1)'(bus2.v_o), '0);
         end else begin
            checkOutput("result_w32", (W+1)'({bus2.c_o, bus2.s_o}), (W+1)'(expQ2[0]));
            if (bus2.yumi_i) void'(expQ2.pop_front());
         end
      end
   end

   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                input bit holdV);
      int waited = 0;
      while (!bus.ready_o && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      checkOutput("ready_before_accept", (W+1)'(bus.ready_o), (W+1)'(1));
      bus.v_i = 1'b1;
      bus.a_i = a;
      bus.b_i = b;
      bus.c_i = c;
      expQ.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
      @(posedge clk); #1;
      bus.v_i = holdV;
      bus.a_i = randWide();
      bus.b_i = randWide();
      bus.c_i = 1'($urandom);
   endtask

   task automatic completeTxn(input int yumiDelay, input bit earlyYumi);
      int lat = 0;
      while (!bus.v_o && lat < 20) begin
         bus.yumi_i = (earlyYumi && lat == 1);
         @(posedge clk); #1;
         bus.a_i = randWide();
         lat++;
      end
      bus.yumi_i = 1'b0;
      checkOutput("latency", (W+1)'(lat), (W+1)'(N));
      repeat (yumiDelay) begin
         @(posedge clk); #1;
         checkOutput("ready_in_done", (W+1)'(bus.ready_o), '0);
      end
      bus.yumi_i = 1'b1;
      @(posedge clk); #1;
      bus.yumi_i = 1'b0;
      bus.v_i    = 1'b0;
      checkOutput("ready_after_yumi", (W+1)'(bus.ready_o), (W+1)'(1));
      checkOutput("v_o_after_yumi", (W+1)'(bus.v_o), '0);
   endtask

   task automatic runSingleChunk(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic c);
      int waited = 0;
      int lat = 0;
      while (!bus2.ready_o && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      bus2.v_i = 1'b1;
      bus2.a_i = a;
      bus2.b_i = b;
      bus2.c_i = c;
      expQ2.push_back({1'b0, a} + {1'b0, b} + {{W2{1'b0}}, c});
      @(posedge clk); #1;
      bus2.v_i = 1'b0;
      bus2.a_i = 32'($urandom);
      while (!bus2.v_o && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("latency_w32", (W+1)'(lat), (W+1)'(1));
      bus2.yumi_i = 1'b1;
      @(posedge clk); #1;
      bus2.yumi_i = 1'b0;
      checkOutput("ready_after_yumi_w32", (W+1)'(bus2.ready_o), (W+1)'(1));
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN        = 1'b0;
      bus.v_i     = 1'b0;
      bus.a_i     = '0;
      bus.b_i     = '0;
      bus.c_i     = 1'b0;
      bus.yumi_i  = 1'b0;
      bus2.v_i    = 1'b0;
      bus2.a_i    = '0;
      bus2.b_i    = '0;
      bus2.c_i    = 1'b0;
      bus2.yumi_i = 1'b0;
      #3;
      checkOutput("reset_ready", (W+1)'(bus.ready_o), (W+1)'(1));
      checkOutput("reset_v_o", (W+1)'(bus.v_o), '0);
      checkOutput("reset_sum", {bus.c_o, bus.s_o}, '0);
      @(posedge clk); #1;
      rstN = 1'b1;

      // Full carry ripple, then a mixed-boundary pattern.
      applyStimulus({W{1'b1}}, '0, 1'b1, 1'b0);
      completeTxn(0, 1'b0);
      applyStimulus(128'h0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0);
      completeTxn(1, 1'b0);

      // v_i kept high with consumer stalled, then an ignored early yumi with a delayed real one.
      applyStimulus(randWide(), randWide(), 1'b1, 1'b1);
      completeTxn(6, 1'b0);
      applyStimulus(randWide(), randWide(), 1'b0, 1'b0);
      completeTxn(3, 1'b1);

      // Asynchronous reset while the third chunk is pending aborts the transaction.
      applyStimulus(randWide(), randWide(), 1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("async_reset_sum", {bus.c_o, bus.s_o}, '0);
      checkOutput("async_reset_ready", (W+1)'(bus.ready_o), (W+1)'(1));
      checkOutput("async_reset_v_o", (W+1)'(bus.v_o), '0);
      expQ.delete();
      @(posedge clk); #1;
      rstN = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         checkOutput("no_v_o_after_abort", (W+1)'(bus.v_o), '0);
      end
      applyStimulus(128'd5, 128'd7, 1'b0, 1'b0);
      completeTxn(0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         applyStimulus(randWide(), randWide(), 1'($urandom), 1'($urandom_range(0, 1)));
         completeTxn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      runSingleChunk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      for (int i = 0; i < 10000; i++) begin
         runSingleChunk(32'($urandom), 32'($urandom), 1'($urandom));
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", (W+1)'(expQ.size() + expQ2.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bsg_adder_serial_chunked.md
BSG_ADDER_SERIAL_CHUNKED -- requirements
Module: bsg_adder_serial_chunked

Interface
REQ-001 The block SHALL have parameter width_p, default 128: total operand width in bits.
REQ-002 The block SHALL have parameter chunk_p, default 32: bits added per cycle; width_p SHALL be an integer multiple of chunk_p (N = width_p/chunk_p, N >= 1).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port v_i, input, 1 bit: operand valid.
REQ-006 The block SHALL have port ready_o, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port a_i, input, width_p bits: operand A.
REQ-008 The block SHALL have port b_i, input, width_p bits: operand B.
REQ-009 The block SHALL have port c_i, input, 1 bit: carry-in into chunk 0.
REQ-010 The block SHALL have port v_o, output, 1 bit: result valid.
REQ-011 The block SHALL have port yumi_i, input, 1 bit: consumer takes result.
REQ-012 The block SHALL have port s_o, output, width_p bits: sum.
REQ-013 The block SHALL have port c_o, output, 1 bit: carry-out of the MSB chunk.

Function
REQ-014 The block SHALL implement the FSM states IDLE, BUSY and DONE, plus a chunk counter 0..N-1 and a registered carry.
REQ-015 ready_o SHALL be 1 only in IDLE; v_o SHALL be 1 only in DONE; both SHALL be driven directly from state with no combinational path from inputs.
REQ-016 Acceptance SHALL occur on an edge where v_i=1 and ready_o=1; it SHALL latch a_i, b_i and c_i, clear the counter, and move to BUSY.
REQ-017 a_i, b_i and c_i SHALL be ignored outside the acceptance edge; operand changes after acceptance SHALL have no effect.
REQ-018 In BUSY, each edge SHALL compute chunk k as {carry, s[k*chunk_p +: chunk_p]} = A chunk k + B chunk k + carry.
REQ-019 Each BUSY edge SHALL also store the chunk sum, update the carry register, and increment k.
REQ-020 On the edge computing chunk N-1, the FSM SHALL move to DONE and c_o SHALL take the final carry.
REQ-021 Latency SHALL be exactly N cycles from the acceptance edge to v_o=1 (4 cycles at the defaults).
REQ-022 When N=1, the single BUSY cycle SHALL go directly to DONE.
REQ-023 Results SHALL be modulo 2^width_p, with overflow reported only on c_o, and equal to a+b+c_i.
REQ-024 s_o and c_o SHALL hold stable throughout DONE until consumed.
REQ-025 yumi_i=1 in DONE SHALL move the FSM to IDLE on that edge, making ready_o=1 in the next cycle.
REQ-026 s_o and c_o SHALL retain their last values in IDLE and BUSY, though only v_o qualifies them.
REQ-027 yumi_i in IDLE or BUSY SHALL be ignored, causing no state change or error.
REQ-028 v_i in BUSY or DONE SHALL be ignored, causing no acceptance and no queuing.
REQ-029 The block SHALL hold at most one transaction; there SHALL be no back-to-back overlap.

Reset
REQ-030 reset_n_i=0 SHALL immediately force state IDLE, counter 0, carry 0, s_o=0, c_o=0, v_o=0, ready_o=1, independent of clk_i.
REQ-031 Reset asserted in BUSY or DONE SHALL abort the transaction; no v_o SHALL appear after release.
REQ-032 After reset deassertion, the first rising edge with v_i=1 SHALL be a valid acceptance edge.

Verification
REQ-033 Defaults, a=2^128-1, b=0, c_i=1 -> after 4 cycles s_o=0, c_o=1; the carry ripples through all chunks.
REQ-034 Defaults, a=0x0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF, b=1, c_i=0 -> s_o=0x0000_0001_FFFF_FFFF_0000_0001_0000_0000, c_o=0.
REQ-035 Defaults, v_i held high and yumi_i held low -> one result, v_o stays 1 with stable s_o, ready_o stays 0, no second acceptance.
REQ-036 Defaults, yumi_i pulsed during BUSY, then after v_o=1 with a 3-cycle yumi_i delay -> early pulse ignored; result correct; ready_o=1 the cycle after yumi_i.
REQ-037 Defaults, reset_n_i pulsed low mid-BUSY (k=2) -> outputs zero asynchronously, ready_o=1, no v_o; next transaction a=5, b=7 -> s_o=12, c_o=0.
REQ-038 width_p=32, chunk_p=32, a=0xFFFF_FFFF, b=0xFFFF_FFFF, c_i=0 -> 1-cycle latency, s_o=0xFFFF_FFFE, c_o=1; a randomized 10k-transaction compare against a+b+c_i SHALL pass.
